// File: rtl/count_ctrl_pkg.sv
// Shared defaults and encodings for the count_ctrl block.
package count_ctrl_pkg;

    // Debounce depth: consecutive stable synchronized samples before a level change.
    localparam int unsigned DbDefault = 4;

    // Auto-increment period in clock cycles while run is high.
    localparam int unsigned PsDefault = 10;

    // Width of the debounce and prescale counters; must hold max(DB, PS-1).
    localparam int unsigned CwDefault = 8;

    // Auto-increment enable, derived from the synchronized run input.
    typedef enum logic {
        AutoOff = 1'b0,
        AutoOn  = 1'b1
    } auto_en_e;

endpackage

// File: rtl/count_ctrl_debounce.sv
// Two-flop synchronizer plus counter-based debouncer for one raw push-button.
// Produces a one-cycle rise strobe when the debounced level goes 0->1.
module debounce
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DB = DbDefault,
    parameter int unsigned CW = CwDefault
) (
    input  logic clk,
    input  logic rst_b,
    input  logic btn,
    output logic rise
);

    // The counter is compared against DB-1 before incrementing, so the level
    // flips on the same edge at which the count would have reached DB.
    localparam logic [CW-1:0] StableLast = CW'(DB - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [CW-1:0] stable_q;
    logic [CW-1:0] stable_d;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; adopt the new level once DB have been seen.
    always_comb begin
        level_d  = level_q;
        stable_d = '0;
        if (sync2_q != level_q) begin
            if (stable_q == StableLast) begin
                level_d = sync2_q;
            end else begin
                stable_d = stable_q + CW'(1);
            end
        end
    end

    // Debounced level, its one-cycle-delayed copy, and the stability counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            stable_q     <= '0;
        end else begin
            level_q      <= level_d;
            level_prev_q <= level_q;
            stable_q     <= stable_d;
        end
    end

    // Rising edge of the debounced level only; releases produce nothing.
    assign rise = level_q & ~level_prev_q;

endmodule

// File: rtl/count_ctrl.sv
// Count-control front end: debounced increment/clear buttons plus a periodic
// auto-increment, producing registered one-cycle c_up and clr pulses for a
// downstream counter. clr always wins over c_up.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DB = DbDefault,
    parameter int unsigned PS = PsDefault,
    parameter int unsigned CW = CwDefault
) (
    input  logic clk,
    input  logic rst_b,
    input  logic btn_up,
    input  logic btn_clr,
    input  logic run,
    output logic c_up,
    output logic clr
);

    localparam logic [CW-1:0] PsLast = CW'(PS - 1);

    logic          up_rise;
    logic          clr_rise;
    logic          run_sync1_q;
    logic          run_sync2_q;
    auto_en_e      auto_en;
    logic [CW-1:0] presc_q;
    logic [CW-1:0] presc_d;
    logic          tick;
    logic          c_up_q;
    logic          c_up_d;
    logic          clr_q;
    logic          clr_d;

    debounce #(
        .DB (DB),
        .CW (CW)
    ) u_debounce_up (
        .clk   (clk),
        .rst_b (rst_b),
        .btn   (btn_up),
        .rise  (up_rise)
    );

    debounce #(
        .DB (DB),
        .CW (CW)
    ) u_debounce_clr (
        .clk   (clk),
        .rst_b (rst_b),
        .btn   (btn_clr),
        .rise  (clr_rise)
    );

    // Two-flop synchronizer for the run level.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            run_sync1_q <= 1'b0;
            run_sync2_q <= 1'b0;
        end else begin
            run_sync1_q <= run;
            run_sync2_q <= run_sync1_q;
        end
    end

    assign auto_en = run_sync2_q ? AutoOn : AutoOff;

    // Tick marks the cycle whose closing edge wraps the prescaler.
    always_comb begin
        tick = (auto_en == AutoOn) && (presc_q == PsLast);
    end

    // Prescaler next state: held at 0 when idle, restarted by a clear, else counts 0..PS-1.
    always_comb begin
        presc_d = presc_q + CW'(1);
        if (clr_rise || (auto_en == AutoOff) || tick) begin
            presc_d = '0;
        end
    end

    // Output next state: clear suppresses any coincident increment; OR merges
    // coincident up-edge and tick into one pulse.
    always_comb begin
        clr_d  = clr_rise;
        c_up_d = (up_rise | tick) & ~clr_rise;
    end

    // Prescaler and registered output pulses.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            presc_q <= '0;
            c_up_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            c_up_q  <= c_up_d;
            clr_q   <= clr_d;
        end
    end

    assign c_up = c_up_q;
    assign clr  = clr_q;

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter DB, default 4, number of consecutive stable samples needed for a debounced button level change (DB >= 1).
REQ-002 Parameter PS, default 10, auto-increment period in clock cycles while run is high (PS >= 2).
REQ-003 Parameter CW, default 8, width of the internal debounce and prescale counters; it SHALL hold max(DB, PS-1).
REQ-004 clk  input  1  single system clock, all state updates on rising edge.
REQ-005 rst_b  input  1  reset, asynchronous, active-low.
REQ-006 btn_up  input  1  raw asynchronous push-button input, increment request.
REQ-007 btn_clr  input  1  raw asynchronous push-button input, clear request.
REQ-008 run  input  1  asynchronous level input, enables periodic auto-increment.
REQ-009 c_up  output  1  registered one-cycle count-enable pulse for the downstream counter.
REQ-010 clr  output  1  registered one-cycle synchronous-clear pulse for the downstream counter.

Function
REQ-011 btn_up, btn_clr and run SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized button SHALL have a debounced level and a stable counter; counter increments while the synchronized value differs from the debounced level, and returns to 0 on any cycle where they are equal.
REQ-013 When the stable counter reaches DB, the debounced level SHALL take the synchronized value and the counter SHALL return to 0 on that same edge.
REQ-014 A 0->1 transition of the debounced up level SHALL produce c_up=1 for exactly one cycle; a 1->0 transition SHALL produce nothing.
REQ-015 A 0->1 transition of the debounced clr level SHALL produce clr=1 for exactly one cycle.
REQ-016 Latency: for a clean press first sampled at edge 1, the debounced level SHALL change at edge DB+2 and the output pulse SHALL be high from edge DB+3 to edge DB+4 (DB=4: edges 7 to 8).
REQ-017 While synchronized run=1, the prescaler SHALL count 0..PS-1, wrap to 0, and raise an internal tick on the edge it wraps; while run=0, it SHALL be held at 0.
REQ-018 c_up SHALL be the registered OR of the up-edge pulse and the tick.
REQ-019 Coincident up-edge and tick SHALL give a single c_up cycle, not two.
REQ-020 A clr pulse SHALL take priority: in any cycle with clr=1, c_up SHALL be 0, and the prescaler SHALL reset to 0 on that edge.
REQ-021 A button held across reset deassertion SHALL be detected as a new press once debounced, because the debounced levels reset to 0.
REQ-022 Pulses lasting fewer than DB synchronized samples SHALL produce no output.

Reset
REQ-023 With rst_b=0, all of the following SHALL go to 0 asynchronously and stay at 0 until rst_b=1: c_up, clr, synchronizer flops, debounced levels, stable counters, prescaler.
REQ-024 Reset asserted mid-debounce or mid-prescale SHALL discard all partial progress, with no output pulse after release.

Structure
REQ-025 The shared package/include SHALL hold the DB, PS and CW defaults and the auto-increment enable encoding; no other typedefs are needed.
REQ-026 The synchronizer plus debounce logic SHALL be one sub-module, debounce, instantiated twice (up, clr). The prescaler and output logic SHALL be in count_ctrl.

Verification (DB=4, PS=10, 100 ns clock; counter downstream with iv=8'hFF)
REQ-027 btn_up held high for 20 cycles, then released -> exactly one c_up pulse, high edge 7 to edge 8, and no pulse on release.
REQ-028 btn_up pattern 1,1,0,1,1,0, then held 1 -> no pulse during the bounce, then exactly one c_up pulse 6 edges after the final rising sample.
REQ-029 run=1 for 40 cycles with no buttons -> c_up pulses spaced exactly 10 cycles apart, each one cycle wide; run=0 -> no further pulses.
REQ-030 run=1, with a btn_clr press timed so clr lands on a tick cycle -> clr=1 and c_up=0 in that cycle, then the next c_up exactly 10 cycles later.
REQ-031 rst_b pulsed low for 5 ns mid-debounce and mid-prescale -> c_up and clr are 0 immediately, and no stale pulse appears after release.
REQ-032 Integrated with the counter: 3 clean btn_up presses -> q=8'h02; then one btn_clr press -> q=8'hFF.
